// File: rtl/ifft_pkg.sv
// ifft_pkg: shared twiddle-table geometry, Q8 constants and sequencer state encoding
package ifft_pkg;
  localparam int TW_ADDR_W = 5;
  localparam int TW_DATA_W = 16;
  localparam int TW_STAGES = 7;
  localparam int TW_LANES  = 4;
  localparam logic [TW_DATA_W-1:0] ONE = 16'h0100;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} tw_state_e;
endpackage

// File: rtl/ifft_twiddle_img_sequencer.sv
// ifft_twiddle_img_sequencer: sweeps the imaginary twiddle ROM and streams coefficients with stage/lane/last tags
module ifft_twiddle_img_sequencer
  import ifft_pkg::*;
#(
  parameter int ADDR_W     = TW_ADDR_W,
  parameter int DATA_W     = TW_DATA_W,
  parameter int NUM_STAGES = TW_STAGES,
  parameter int LANES      = TW_LANES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic [DATA_W-1:0]        tw_data,
  output logic                     tw_valid,
  input  logic                     tw_ready,
  output logic [2:0]               tw_stage,
  output logic [$clog2(LANES)-1:0] tw_lane,
  output logic                     tw_last,
  output logic                     busy,
  output logic                     done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_STAGES * LANES - 1);
  tw_state_e         r_state, w_next;
  logic [ADDR_W-1:0] r_idx;
  logic              w_accept, w_at_last;
  assign w_at_last = r_idx == LAST;
  assign w_accept  = (r_state == STREAM) & tw_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // The terminal compare gates the increment, so idx never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_idx <= '0;
    else if (r_state == DONE)         r_idx <= '0;
    else if (w_accept && !w_at_last)  r_idx <= r_idx + ADDR_W'(1);
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)   ? (start ? STREAM : IDLE) :
             (r_state == STREAM) ? ((w_accept && w_at_last) ? DONE : STREAM) :
                                   IDLE;
  end
  // Address runs one item ahead on accept so the ROM latency is hidden; a stall re-reads idx.
  always_comb begin
    tw_valid = r_state == STREAM;
    busy     = r_state == STREAM;
    done     = r_state == DONE;
    tw_last  = (r_state == STREAM) & w_at_last;
    rom_addr = (r_state == IDLE) ? '0 : (w_accept && !w_at_last) ? r_idx + ADDR_W'(1) : r_idx;
    tw_data  = rom_data;
    tw_stage = 3'(r_idx >> $clog2(LANES));
    tw_lane  = r_idx[$clog2(LANES)-1:0];
  end
endmodule
